// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES (Inv)MixColumns: captures a 128-bit state, then mixes one
// 32-bit column per clock into a registered result held until accepted.
module inv_mix_columns_seq #(
  parameter bit INVERSE = 1'b1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] InState,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] OutState,
  output logic         Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   col;
  logic [127:0] hold;
  logic [31:0]  cur_col;
  logic [31:0]  mixed_col;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficient products built from repeated xtime; only 02/03/09/0B/0D/0E are needed.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m2[i] = x2[i];
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (INVERSE) begin
      mix_column = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end else begin
      mix_column = {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                    m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    end
  endfunction

  always_comb begin
    cur_col = 32'h0;
    case (col)
      2'd0:    cur_col = hold[127:96];
      2'd1:    cur_col = hold[95:64];
      2'd2:    cur_col = hold[63:32];
      default: cur_col = hold[31:0];
    endcase
  end

  assign mixed_col = mix_column(cur_col);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      col      <= 2'd0;
      hold     <= 128'h0;
      OutState <= 128'h0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            hold  <= InState;
            col   <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          case (col)
            2'd0:    OutState[127:96] <= mixed_col;
            2'd1:    OutState[95:64]  <= mixed_col;
            2'd2:    OutState[63:32]  <= mixed_col;
            default: OutState[31:0]   <= mixed_col;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          // No accept on the handshake edge; IDLE is visible one cycle later.
          if (OutReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq using FIPS-197 MixColumns column pairs
// (inverse DUT plus a forward instance for the round-trip case).
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic         f_in_valid;
  logic         f_in_ready;
  logic [127:0] f_in_state;
  logic         f_out_valid;
  logic         f_out_ready;
  logic [127:0] f_out_state;
  logic         f_busy;

  int total;
  int bad;

  inv_mix_columns_seq #(.INVERSE(1'b1)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .InValid(in_valid), .InReady(in_ready), .InState(in_state),
    .OutValid(out_valid), .OutReady(out_ready), .OutState(out_state),
    .Busy(busy)
  );

  inv_mix_columns_seq #(.INVERSE(1'b0)) fwd (
    .Clk(clk), .Rst_n(rst_n),
    .InValid(f_in_valid), .InReady(f_in_ready), .InState(f_in_state),
    .OutValid(f_out_valid), .OutReady(f_out_ready), .OutState(f_out_state),
    .Busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state to the inverse DUT and return right after the accepting edge.
  task automatic apply_stimulus(input logic [127:0] s);
    int guard;
    in_state = s;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_output("accept_ready", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_output(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  localparam logic [127:0] T1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] T1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] T2_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] T2_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] T5_IN  = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
  localparam logic [127:0] T5_OUT = 128'h2d26314c_2d26314c_2d26314c_2d26314c;

  logic [127:0] s_in  [3];
  logic [127:0] s_out [3];

  initial begin
    int lat;
    int cyc;
    int acc;
    int seen;
    int last_seen;
    logic rdy_before;

    total = 0;
    bad = 0;
    s_in[0]  = 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d;
    s_out[0] = 128'h2d26314c_d4d4d4d5_db135345_f20a225c;
    s_in[1]  = 128'h01000000_c6c6c6c6_ffffffff_01010101;
    s_out[1] = 128'h0e090d0b_c6c6c6c6_ffffffff_01010101;
    s_in[2]  = 128'h9fdc589d_00000000_4d7ebdf8_8e4da1bc;
    s_out[2] = 128'hf20a225c_00000000_2d26314c_db135345;

    in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
    f_in_valid = 1'b0; f_in_state = '0; f_out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check_output("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check_output("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_output("rst_busy", {127'd0, busy}, 128'd0);
    check_output("rst_out_state", out_state, 128'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: basic inverse transfer with latency
    apply_stimulus(T1_IN);
    check_output("t1_busy", {127'd0, busy}, 128'd1);
    wait_output(lat);
    check_output("t1_latency", 128'(lat), 128'd4);
    check_output("t1_result", out_state, T1_OUT);
    tick();
    check_output("t1_idle_valid", {127'd0, out_valid}, 128'd0);
    check_output("t1_idle_ready", {127'd0, in_ready}, 128'd1);

    // Test 2: forward then inverse round trip
    f_in_state = T2_IN;
    f_in_valid = 1'b1;
    tick();
    f_in_valid = 1'b0;
    lat = 0;
    while (!f_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_output("t2_fwd_latency", 128'(lat), 128'd4);
    check_output("t2_fwd_result", f_out_state, T2_FWD);
    apply_stimulus(f_out_state);
    wait_output(lat);
    check_output("t2_roundtrip", out_state, T2_IN);
    tick();

    // Test 3: backpressure in DONE
    out_ready = 1'b0;
    apply_stimulus(T1_IN);
    wait_output(lat);
    check_output("t3_result", out_state, T1_OUT);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_state = {4{32'h12345678 + 32'(i)}};
      tick();
      check_output("t3_hold_valid", {127'd0, out_valid}, 128'd1);
      check_output("t3_hold_ready", {127'd0, in_ready}, 128'd0);
      check_output("t3_hold_state", out_state, T1_OUT);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_output("t3_release_valid", {127'd0, out_valid}, 128'd0);
    check_output("t3_release_ready", {127'd0, in_ready}, 128'd1);

    // Test 4: input changes after capture have no effect
    apply_stimulus(T1_IN);
    in_state = {128{1'b1}};
    wait_output(lat);
    check_output("t4_latency", 128'(lat), 128'd4);
    check_output("t4_result", out_state, T1_OUT);
    tick();

    // Test 5: asynchronous reset mid-RUN
    apply_stimulus(T5_IN);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_valid", {127'd0, out_valid}, 128'd0);
    check_output("t5_rst_ready", {127'd0, in_ready}, 128'd1);
    check_output("t5_rst_state", out_state, 128'd0);
    #2;
    rst_n = 1'b1;
    tick();
    apply_stimulus(T5_IN);
    wait_output(lat);
    check_output("t5_result", out_state, T5_OUT);
    tick();

    // Test 6: back-to-back with InValid held high
    in_state = s_in[0];
    in_valid = 1'b1;
    acc = 0;
    seen = 0;
    last_seen = 0;
    cyc = 0;
    while (seen < 3 && cyc < 60) begin
      rdy_before = in_ready;
      tick();
      cyc++;
      if (rdy_before && in_valid) begin
        acc++;
        if (acc < 3) in_state = s_in[acc];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check_output($sformatf("t6_result%0d", seen), out_state, s_out[seen]);
        if (seen > 0) check_output($sformatf("t6_spacing%0d", seen), 128'(cyc - last_seen), 128'd6);
        last_seen = cyc;
        seen++;
      end
    end
    in_valid = 1'b0;
    check_output("t6_count", 128'(seen), 128'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Column-serial AES MixColumns engine, one 32-bit column per clock.
- Default mode is the decrypt-direction InvMixColumns, with coefficients 0E/0B/0D/09. The same RTL builds the encrypt-direction MixColumns (coefficients 02/03/01/01) through a parameter.
- Sits in the decrypt round datapath between InvShiftRows/InvSubBytes/AddRoundKey and the next round register.
- Uses valid/ready handshakes on both sides so round control can stall it.

Parameters:
- INVERSE, 1: 1 = InvMixColumns; 0 = forward MixColumns. Static; no runtime switching.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- InValid  input  1  InState is valid
- InReady  output  1  block can accept a state
- InState  input  128  input state
- OutValid  output  1  OutState is valid
- OutReady  input  1  downstream accepts OutState
- OutState  output  128  result state, registered
- Busy  output  1  high in RUN or DONE

Behaviour:
- Byte order (FIPS-197):
  - Byte k = InState[127-8k -: 8], with k = 4c + r (column c, row r).
  - Column c = InState[127-32c -: 32]. OutState uses the same mapping.
- Column math, INVERSE=1, for column bytes a0..a3:
  - o0 = E·a0 ^ B·a1 ^ D·a2 ^ 9·a3
  - o1 = 9·a0 ^ E·a1 ^ B·a2 ^ D·a3
  - o2 = D·a0 ^ 9·a1 ^ E·a2 ^ B·a3
  - o3 = B·a0 ^ D·a1 ^ 9·a2 ^ E·a3
- Column math, INVERSE=0:
  - o0 = 2a0 ^ 3a1 ^ a2 ^ a3, rotated likewise for o1..o3.
- GF arithmetic:
  - All multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1; xtime reduces with 8'h1b.
  - The per-column multiply/XOR is combinational, computed inside the block from the held state register. It adds no extra pipeline stages.
- Reset (Rst_n low, asynchronous):
  - State = IDLE, col = 0.
  - InReady = 1, OutValid = 0, Busy = 0.
  - OutState = 0, internal state register = 0.
- FSM IDLE:
  - InReady = 1.
  - On InValid & InReady at an edge: capture InState into the hold register, col <= 0, go to RUN.
- FSM RUN:
  - InReady = 0.
  - Each edge writes the mix of held column col into OutState column col, then col <= col + 1.
  - The edge that writes col = 3 goes to DONE. col is 2 bits and wraps to 0.
- FSM DONE:
  - OutValid = 1, InReady = 0.
  - OutState stays stable until the handshake.
  - On OutValid & OutReady: OutValid <= 0, go to IDLE.
  - A new input is not accepted in the handshake cycle; the earliest accept is the next cycle.
- Latency and throughput:
  - Acceptance edge E0; OutValid rises after edge E4 (4 cycles).
  - With OutReady held high: throughput is 1 state per 6 cycles.
- Stalls:
  - OutReady low in DONE holds the state indefinitely; OutState and OutValid do not change.
- Input side during RUN/DONE:
  - InValid is ignored and InState changes have no effect, because the hold register is already captured.
- Partially written columns:
  - OutState is a don't-care while OutValid = 0. The bench must only check it when OutValid = 1.
- Reset mid-operation (RUN or DONE): immediate return to reset values; the partial result is discarded.
- Busy = (state != IDLE); it equals ~InReady.

Test Plan:
1. Reset, then accept InState = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 with OutReady = 1 -> OutValid exactly 4 cycles after acceptance, OutState = db135345_f20a225c_01010101_d4d4d4d5, then one cycle back in IDLE.
2. Round trip: build INVERSE=0 and INVERSE=1 instances back to back; input db135345_f20a225c_01010101_c6c6c6c6 -> forward yields 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> inverse returns the original.
3. Backpressure: hold OutReady = 0 for 10 cycles in DONE -> OutValid stays 1, OutState is unchanged, InReady = 0, and InValid pulses are ignored. Release -> OutValid drops after 1 edge.
4. Input change during RUN: change InState to all-ff on the cycle after acceptance -> the result still matches the captured state from test 1.
5. Assert Rst_n low asynchronously mid-RUN at col = 2 -> OutValid = 0, InReady = 1, and OutState = 0 without waiting for an edge. A subsequent transfer of 2d26314c_... with inverse on 4d7ebdf8 returns 2d26314c.
6. Back-to-back: InValid held high with 3 distinct states and OutReady = 1 -> 3 outputs in order, spaced 6 cycles apart, each matching the reference model.
